// File: rtl/i2c_cmd_sequencer_if.sv
// Host command/response and i2c_master-facing signals of i2c_cmd_sequencer.
// The slave modport is the sequencer's view; master is the host/master-side view.
`timescale 1ns/1ps
interface i2c_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       busy;
    logic       timeout_err;
    logic       err_clr;
    logic [6:0] m_addr;
    logic [7:0] m_data_write;
    logic       m_rw;
    logic       m_enable;
    logic       m_ready;
    logic [7:0] m_data_read;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, err_clr, m_ready, m_data_read,
        output cmd_ready, rsp_valid, rsp_data, busy, timeout_err, m_addr, m_data_write, m_rw, m_enable
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, err_clr, m_ready, m_data_read,
        input  cmd_ready, rsp_valid, rsp_data, busy, timeout_err, m_addr, m_data_write, m_rw, m_enable
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO front-end for i2c_master: issues queued transactions one at a time,
// returns read bytes through a single response register, flags stalls as timeout_err.
`timescale 1ns/1ps
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam int unsigned    CW       = $clog2(TIMEOUT);
    localparam logic [AW:0]    PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_RESP} state_t;
    state_t state, state_n;

    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic [15:0]   head;
    logic [CW-1:0] cnt;
    logic          cnt_clr, cnt_inc, rsp_load, rsp_clr, to_set;

    logic [6:0]    m_addr_q;
    logic [7:0]    m_data_q;
    logic          m_rw_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          err_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.cmd_valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        rsp_load = 1'b0;
        rsp_clr  = 1'b0;
        to_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && bus.m_ready) begin
                    pop     = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!bus.m_ready) begin
                    cnt_clr = 1'b1;
                    state_n = S_WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    to_set  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.m_ready) begin
                    if (m_rw_q) begin
                        rsp_load = 1'b1;
                        state_n  = S_RESP;
                    end else begin
                        state_n  = S_IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    to_set  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_clr = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_rw_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr                       <= rd_ptr + PTR_ONE;
                {m_rw_q, m_addr_q, m_data_q} <= head;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_ONE;
            end
            if (rsp_load) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.m_data_read;
            end else if (rsp_clr) begin
                rsp_valid_q <= 1'b0;
            end
            // A timeout in the same cycle as err_clr leaves the flag set.
            if (to_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.busy         = !empty || (state != S_IDLE);
    assign bus.timeout_err  = err_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.m_addr       = m_addr_q;
    assign bus.m_data_write = m_data_q;
    assign bus.m_rw         = m_rw_q;
    assign bus.m_enable     = (state == S_LAUNCH);
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a small i2c_master behavioural stand-in.
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if bus();

    i2c_cmd_sequencer #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Master stand-in: accepts on enable, stays busy a few cycles, then returns ready.
    logic       auto_mode   = 1'b0;
    logic       force_ready = 1'b1;
    logic       model_ready = 1'b1;
    int         lat         = 0;
    logic [7:0] slave_byte  = 8'h00;
    logic [7:0] wlog[$];

    assign bus.m_ready     = auto_mode ? model_ready : force_ready;
    assign bus.m_data_read = slave_byte;

    always @(negedge clk) begin
        if (!rst) begin
            model_ready = 1'b1;
        end else if (auto_mode) begin
            if (model_ready && bus.m_enable) begin
                if (!bus.m_rw) wlog.push_back(bus.m_data_write);
                model_ready = 1'b0;
                lat = 3;
            end else if (!model_ready) begin
                if (lat == 0) model_ready = 1'b1;
                else lat--;
            end
        end
    end

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.timeout_err, bus.m_enable, bus.m_rw} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000",
                     {bus.rsp_valid, bus.busy, bus.timeout_err, bus.m_enable, bus.m_rw});
        end
        checks++;
        if ({bus.m_addr, bus.m_data_write, bus.rsp_data} !== 23'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", {bus.m_addr, bus.m_data_write, bus.rsp_data});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b expected ready=1 busy=0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_single_write;
        int base = wlog.size();
        int n = 0;
        push_cmd(1'b0, 7'h55, 8'hAA);
        checks++;
        if (bus.m_enable !== 1'b0) begin
            errors++;
            $display("FAIL wr_enable_early got %b expected 0", bus.m_enable);
        end
        @(negedge clk);
        checks++;
        if (bus.m_enable !== 1'b1) begin
            errors++;
            $display("FAIL wr_enable_rise got %b expected 1", bus.m_enable);
        end
        checks++;
        if ({bus.m_rw, bus.m_addr, bus.m_data_write} !== {1'b0, 7'h55, 8'hAA}) begin
            errors++;
            $display("FAIL wr_master_fields got rw=%b addr=%h data=%h expected rw=0 addr=55 data=aa",
                     bus.m_rw, bus.m_addr, bus.m_data_write);
        end
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_busy_clear got %b expected 0", bus.busy);
        end
        checks++;
        if (wlog.size() != base + 1) begin
            errors++;
            $display("FAIL wr_slave_count got %0d expected %0d", wlog.size(), base + 1);
        end else if (wlog[base] !== 8'hAA) begin
            errors++;
            $display("FAIL wr_slave_byte got %h expected aa", wlog[base]);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_rsp got %b expected 0", bus.rsp_valid);
        end
    endtask

    task automatic test_single_read;
        int n = 0;
        logic held = 1'b1;
        slave_byte = 8'h29;
        push_cmd(1'b1, 7'h55, 8'h00);
        while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h29) begin
            errors++;
            $display("FAIL rd_rsp got valid=%b data=%h expected valid=1 data=29", bus.rsp_valid, bus.rsp_data);
        end
        checks++;
        if (bus.m_rw !== 1'b1 || bus.m_addr !== 7'h55) begin
            errors++;
            $display("FAIL rd_master_fields got rw=%b addr=%h expected rw=1 addr=55", bus.m_rw, bus.m_addr);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h29) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL rd_rsp_hold got %b expected 1", held);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_rsp_consume got valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        int   base = wlog.size();
        int   n = 0;
        logic exp;
        logic order_ok = 1'b1;
        auto_mode   = 1'b0;
        force_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b0, 7'h20, 8'(i + 1));
            exp = (i < 3);
            checks++;
            if (bus.cmd_ready !== exp) begin
                errors++;
                $display("FAIL bp_ready_fill%0d got %b expected %b", i + 1, bus.cmd_ready, exp);
            end
        end
        push_cmd(1'b0, 7'h20, 8'hEE);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full got %b expected 0", bus.cmd_ready);
        end
        force_ready = 1'b1;
        auto_mode   = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_pop got %b expected 1", bus.cmd_ready);
        end
        while (bus.busy && n < 200) begin @(negedge clk); n++; end
        if (wlog.size() != base + 4) order_ok = 1'b0;
        else for (int i = 0; i < 4; i++) if (wlog[base + i] !== 8'(i + 1)) order_ok = 1'b0;
        checks++;
        if (order_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_order got count=%0d expected 4 bytes 01..04", wlog.size() - base);
        end
    endtask

    task automatic test_read_blocks_queue;
        int   base = wlog.size();
        int   n = 0;
        logic blocked = 1'b1;
        slave_byte = 8'hC3;
        push_cmd(1'b1, 7'h12, 8'h00);
        push_cmd(1'b0, 7'h12, 8'h5A);
        while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'hC3) begin
            errors++;
            $display("FAIL rbq_rsp got valid=%b data=%h expected valid=1 data=c3", bus.rsp_valid, bus.rsp_data);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_enable !== 1'b0 || wlog.size() != base) blocked = 1'b0;
        end
        checks++;
        if (blocked !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rbq_blocked got blocked=%b busy=%b expected 1 1", blocked, bus.busy);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n = 0;
        while (wlog.size() == base && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (wlog.size() != base + 1) begin
            errors++;
            $display("FAIL rbq_write_issue got count=%0d expected 1", wlog.size() - base);
        end else if (wlog[base] !== 8'h5A) begin
            errors++;
            $display("FAIL rbq_write_byte got %h expected 5a", wlog[base]);
        end
        n = 0;
        while (bus.busy && n < 50) begin @(negedge clk); n++; end
    endtask

    task automatic test_timeout;
        int n = 0;
        auto_mode   = 1'b0;
        force_ready = 1'b1;
        push_cmd(1'b0, 7'h11, 8'h77);
        while (!bus.m_enable && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (bus.m_enable && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL to_enable_cycles got %0d expected 16", n);
        end
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_flag got err=%b busy=%b expected err=1 busy=0", bus.timeout_err, bus.busy);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got %b expected 0", bus.timeout_err);
        end
    endtask

    task automatic test_async_reset;
        auto_mode   = 1'b0;
        force_ready = 1'b1;
        push_cmd(1'b0, 7'h33, 8'h10);
        push_cmd(1'b0, 7'h33, 8'h11);
        push_cmd(1'b0, 7'h33, 8'h12);
        force_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_enable !== 1'b0 || bus.busy !== 1'b1 || bus.m_addr !== 7'h33) begin
            errors++;
            $display("FAIL ar_pre got en=%b busy=%b addr=%h expected 0 1 33", bus.m_enable, bus.busy, bus.m_addr);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.timeout_err, bus.m_enable, bus.m_rw, bus.m_addr,
             bus.m_data_write, bus.rsp_data} !== 28'h0) begin
            errors++;
            $display("FAIL ar_async got busy=%b en=%b addr=%h data=%h expected all 0",
                     bus.busy, bus.m_enable, bus.m_addr, bus.m_data_write);
        end
        @(negedge clk);
        rst         = 1'b1;
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.m_enable !== 1'b0) begin
            errors++;
            $display("FAIL ar_release got busy=%b ready=%b en=%b expected 0 1 0",
                     bus.busy, bus.cmd_ready, bus.m_enable);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = 7'h00;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.err_clr   = 1'b0;
        test_reset();
        auto_mode = 1'b1;
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_read_blocks_queue();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
Command front-end that sits directly upstream of i2c_master and drives its addr/data_write_master/rw/enable inputs. Host logic pushes I2C transactions into a small command FIFO. The sequencer issues them to the master one at a time using the master's ready handshake, and returns read bytes through a single-entry response register. It also flags a sticky timeout error if the master stalls.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2.
TIMEOUT, 4096, max clk cycles allowed in LAUNCH or WAIT_DONE before abort.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
cmd_valid  in  1  host command strobe; push occurs when cmd_valid & cmd_ready
cmd_ready  out  1  FIFO not full
cmd_rw  in  1  0 = write, 1 = read
cmd_addr  in  7  slave address
cmd_data  in  8  write byte; ignored for reads
rsp_valid  out  1  read byte available
rsp_data  out  8  read byte
rsp_ready  in  1  host consumes response when rsp_valid & rsp_ready
busy  out  1  FIFO non-empty or state != IDLE
timeout_err  out  1  sticky; set on timeout
err_clr  in  1  clears timeout_err
m_addr  out  7  to master addr
m_data_write  out  8  to master data_write_master
m_rw  out  1  to master rw
m_enable  out  1  to master enable
m_ready  in  1  from master ready (1 = idle)
m_data_read  in  8  from master data_read_master

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, counter 0. cmd_ready=1 after release. rsp_valid=0, rsp_data=0, busy=0, timeout_err=0, m_enable=0, m_addr=0, m_data_write=0, m_rw=0. Reset mid-transaction aborts immediately; queued commands are lost.
- FIFO: 16-bit entries {rw,addr,data}. Pointer width log2(DEPTH)+1; wrap by natural overflow. cmd_ready=!full.
- A push and a pop in the same cycle are both honoured; count is unchanged. A push to an empty FIFO is poppable on the next cycle, not the same cycle.
- IDLE: if FIFO non-empty and m_ready=1, pop the head and register it onto m_addr/m_data_write/m_rw, then go to LAUNCH. m_* hold their values until the next pop.
- LAUNCH: m_enable=1. If m_ready=0 is sampled, go to WAIT_DONE and drive m_enable=0 from that edge. m_enable is never high in any other state.
- WAIT_DONE: wait for m_ready=1. For a write, go to IDLE. For a read, load rsp_data<=m_data_read, set rsp_valid=1, and go to RESP.
- RESP: hold rsp_valid and rsp_data until rsp_ready=1, then clear rsp_valid and go to IDLE. No further command issues while a read response is pending.
- Timeout: the counter clears on entry to LAUNCH and on entry to WAIT_DONE, and increments each cycle in either state. If it reaches TIMEOUT-1 without the exit condition, drop m_enable, set timeout_err, and go to IDLE. The command is dropped, and no response is produced for a read.
- timeout_err: sticky. err_clr clears it. If a set and err_clr occur in the same cycle, the set wins.
- Minimum issue gap: the command pops in IDLE and m_enable rises on the next cycle (1 cycle pop-to-enable).

Test Plan:
- Single write: push rw=0 addr=7'h55 data=8'hAA. -> m_enable rises 2 cycles after the push (1 cycle to become poppable, 1 cycle pop-to-enable). Master completes on i2c_slave. Slave data_read_slave=8'hAA. busy returns to 0. rsp_valid stays 0.
- Single read: slave data_write_slave=8'h29; push rw=1 addr=7'h55. -> rsp_valid=1 with rsp_data=8'h29. The response holds with rsp_ready=0 for 20 cycles, then clears 1 cycle after rsp_ready=1.
- Back-pressure: push 4 writes with no gap (data 8'h01..8'h04). -> cmd_ready=0 exactly when 4 entries are held, then deasserts/reasserts as pops occur. Slave sees 01,02,03,04 in order. No command is lost or duplicated.
- Read blocks queue: push read then write 8'h5A, keeping rsp_ready=0. -> the write's m_enable stays 0 until the response is consumed, then the write issues.
- Timeout: TIMEOUT=16, with a stub master holding m_ready=1 forever. -> m_enable high 16 cycles, then timeout_err=1 and state IDLE. err_clr pulse -> timeout_err=0.
- Async reset mid-transfer: assert rst=0 while in WAIT_DONE with 2 queued commands. -> all outputs reach reset values without a clock edge. After release, busy=0 and cmd_ready=1.
